// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port (CPU/debug) arbiter for the cache_system data port
// One latched transaction at a time; CPU has priority unless the debug port has been starved.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_read_en,
  input  logic        c_write_en,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [1:0]  c_control,
  output logic [31:0] c_rdata,
  output logic        c_busywait,
  input  logic        d_read_en,
  input  logic        d_write_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_control,
  output logic [31:0] d_rdata,
  output logic        d_busywait,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_control,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busywait,
  output logic        owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [7:0] STARVE_MAX   = 8'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] starve_cnt;
  logic [7:0] timeout_cnt;
  logic       c_req;
  logic       d_req;
  logic       grant_d;
  logic       mem_done;
  logic       mem_abort;

  assign c_req = c_read_en | c_write_en;
  assign d_req = d_read_en | d_write_en;

  // A requester is released only during the COMPLETE cycle of its own grant.
  assign c_busywait = c_req & ~((state == COMPLETE) & ~owner);
  assign d_busywait = d_req & ~((state == COMPLETE) & owner);

  always_comb begin
    state_next = state;
    grant_d    = d_req & (~c_req | (starve_cnt == STARVE_MAX));
    mem_done   = (state == BUSY) & ~mem_busywait;
    mem_abort  = (state == BUSY) & mem_busywait & (timeout_cnt == TIMEOUT_LAST);
    case (state)
      IDLE:     if (c_req | d_req) state_next = BUSY;
      BUSY:     if (mem_done | mem_abort) state_next = COMPLETE;
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_control  <= 2'd0;
      c_rdata      <= 32'd0;
      d_rdata      <= 32'd0;
      owner        <= 1'b0;
      timeout_err  <= 1'b0;
      starve_cnt   <= 8'd0;
      timeout_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          timeout_cnt <= 8'd0;
          if (c_req | d_req) begin
            owner <= grant_d;
            // Both enables high on one port is a write.
            if (grant_d) begin
              mem_addr     <= d_addr;
              mem_wdata    <= d_wdata;
              mem_control  <= d_control;
              mem_write_en <= d_write_en;
              mem_read_en  <= d_read_en & ~d_write_en;
            end else begin
              mem_addr     <= c_addr;
              mem_wdata    <= c_wdata;
              mem_control  <= c_control;
              mem_write_en <= c_write_en;
              mem_read_en  <= c_read_en & ~c_write_en;
            end
          end
          // D idle or granted resets the count; a CPU grant over a waiting D bumps it.
          if (~d_req | grant_d) starve_cnt <= 8'd0;
          else                  starve_cnt <= starve_cnt + 8'd1;
        end
        BUSY: begin
          if (mem_done) begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            if (mem_read_en) begin
              if (owner) d_rdata <= mem_rdata;
              else       c_rdata <= mem_rdata;
            end
          end else if (mem_abort) begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            timeout_err  <= 1'b1;
            if (owner) d_rdata <= 32'd0;
            else       c_rdata <= 32'd0;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        COMPLETE: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
          timeout_cnt  <= 8'd0;
        end
        default: begin
          mem_read_en  <= 1'b0;
          mem_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
